fs_accel_acc_quant: RTL and testbench

Output stage directly downstream of the 3x3 processing unit. Consumes the unit's registered 32-bit window sums, accumulates `cfg_num_ch` partial sums (one per input channel) into one output pixel, adds bias, requantizes with a fixed-point multiplier and rounding right shift, adds the output offset, and clamps to int8. It uses a valid/ready handshake on both sides. `in_rdy` drives the PU enable path so upstream stalls under output backpressure.

---
 rtl/fs_accel_acc_quant.sv | 132 +++++++++++++
 tb/tb_fs_accel_acc_quant.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fs_accel_acc_quant.sv
// Accumulate / bias / Q31 requant / clamp output stage behind the 3x3 PU.
// Define FS_ACCEL_ACC_QUANT_SAT_EN to make the accumulate and bias adds saturate instead of wrap.
module fs_accel_acc_quant #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic                    acc_in_vld,
  output logic                    in_rdy,
  input  logic [CNT_W-1:0]        cfg_num_ch,
  input  logic signed [31:0]      cfg_bias,
  input  logic signed [31:0]      cfg_mult,
  input  logic [4:0]              cfg_shift,
  input  logic signed [31:0]      cfg_out_offset,
  input  logic signed [7:0]       cfg_act_min,
  input  logic signed [7:0]       cfg_act_max,
  output logic signed [7:0]       out_data,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic                    busy
);

  localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] INT32_MAX = 32'sh7FFF_FFFF;

  // Shared by the channel accumulate and the bias add.
  function automatic logic signed [31:0] add_op(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
`ifdef FS_ACCEL_ACC_QUANT_SAT_EN
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return s[32] ? INT32_MIN : INT32_MAX;
    return s[31:0];
`else
    return a + b;
`endif
  endfunction

  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        ch_cnt;
  logic                    st1_vld, st2_vld, st3_vld;
  logic signed [31:0]      st1_sum, st2_s1, st3_h;

  logic                    stall, accept, last_ch;
  logic [CNT_W-1:0]        ch_last;
  logic signed [31:0]      acc_next;

  assign stall   = out_vld && !out_rdy;
  assign in_rdy  = !stall;
  assign accept  = acc_in_vld && in_rdy;
  assign ch_last = (cfg_num_ch == '0) ? '0 : cfg_num_ch - 1'b1;
  assign last_ch = (ch_cnt >= ch_last);
  assign acc_next = add_op(acc, acc_in);
  assign busy    = (ch_cnt != '0) || st1_vld || st2_vld || st3_vld || out_vld;

  // Stage 2 datapath: Q31 multiply with round-half-up, INT32_MIN^2 pinned to INT32_MAX.
  logic signed [63:0] prod, prod_rnd;
  logic signed [31:0] h_next;
  logic               unused_prod_bits;

  always_comb begin
    prod     = 64'(st2_s1) * 64'(cfg_mult);
    prod_rnd = prod + 64'sh4000_0000;
    h_next   = prod_rnd[62:31];
    if (st2_s1 == INT32_MIN && cfg_mult == INT32_MIN) h_next = INT32_MAX;
  end

  assign unused_prod_bits = ^{prod_rnd[63], prod_rnd[30:0]};

  // Stage 3 datapath: rounding shift, zero point, clamp.
  logic signed [32:0] h_rnd, r_val;
  logic signed [33:0] o_val, lo, hi;
  logic signed [7:0]  q_next;

  always_comb begin
    h_rnd = {st3_h[31], st3_h};
    if (cfg_shift != 5'd0) h_rnd = h_rnd + (33'sd1 <<< (cfg_shift - 5'd1));
    r_val = h_rnd >>> cfg_shift;
    o_val = {r_val[32], r_val} + {{2{cfg_out_offset[31]}}, cfg_out_offset};
    lo    = {{26{cfg_act_min[7]}}, cfg_act_min};
    hi    = {{26{cfg_act_max[7]}}, cfg_act_max};
    if (o_val < lo)      q_next = cfg_act_min;
    else if (o_val > hi) q_next = cfg_act_max;
    else                 q_next = o_val[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      ch_cnt   <= '0;
      st1_vld  <= 1'b0;
      st2_vld  <= 1'b0;
      st3_vld  <= 1'b0;
      st1_sum  <= '0;
      st2_s1   <= '0;
      st3_h    <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (clear) begin
      // Config and data registers survive a flush; only occupancy is cleared.
      acc     <= '0;
      ch_cnt  <= '0;
      st1_vld <= 1'b0;
      st2_vld <= 1'b0;
      st3_vld <= 1'b0;
      out_vld <= 1'b0;
    end else if (!stall) begin
      st1_vld <= accept && last_ch;
      if (accept) begin
        if (last_ch) begin
          st1_sum <= acc_next;
          acc     <= '0;
          ch_cnt  <= '0;
        end else begin
          acc    <= acc_next;
          ch_cnt <= ch_cnt + 1'b1;
        end
      end
      st2_vld <= st1_vld;
      st2_s1  <= add_op(st1_sum, cfg_bias);
      st3_vld <= st2_vld;
      st3_h   <= h_next;
      out_vld <= st3_vld;
      // NOTE: out_data loads only with a valid result so a consumed value is never overwritten by a bubble.
      if (st3_vld) out_data <= q_next;
    end
  end

endmodule

// File: tb/tb_fs_accel_acc_quant.sv
// Self-checking bench for fs_accel_acc_quant: directed plan cases plus randomized traffic
// against an arithmetic reference model.
module tb_fs_accel_acc_quant;

  logic               clk = 1'b0;
  logic               reset, clear, acc_in_vld, out_rdy;
  logic signed [31:0] acc_in;
  logic               in_rdy, out_vld, busy;
  logic [15:0]        cfg_num_ch;
  logic signed [31:0] cfg_bias, cfg_mult, cfg_out_offset;
  logic [4:0]         cfg_shift;
  logic signed [7:0]  cfg_act_min, cfg_act_max, out_data;

  int checks = 0;
  int errors = 0;

  fs_accel_acc_quant dut (
    .clk(clk), .reset(reset), .clear(clear),
    .acc_in(acc_in), .acc_in_vld(acc_in_vld), .in_rdy(in_rdy),
    .cfg_num_ch(cfg_num_ch), .cfg_bias(cfg_bias), .cfg_mult(cfg_mult),
    .cfg_shift(cfg_shift), .cfg_out_offset(cfg_out_offset),
    .cfg_act_min(cfg_act_min), .cfg_act_max(cfg_act_max),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int model_add(input int a, input int b);
    longint s;
    s = longint'(a) + longint'(b);
`ifdef FS_ACCEL_ACC_QUANT_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return int'(s);
  endfunction

  function automatic int model_quant(input int s1);
    longint p, h, r, o;
    int     hh;
    p  = longint'(s1) * longint'(cfg_mult);
    h  = (p + (longint'(1) << 30)) >>> 31;
    hh = int'(h);
    if (s1 == 32'sh8000_0000 && cfg_mult == 32'sh8000_0000) hh = 32'sh7FFF_FFFF;
    r = longint'(hh);
    if (cfg_shift != 0) r = r + (longint'(1) << (cfg_shift - 1));
    r = r >>> cfg_shift;
    o = r + longint'(cfg_out_offset);
    if (o < longint'(cfg_act_min)) o = longint'(cfg_act_min);
    if (o > longint'(cfg_act_max)) o = longint'(cfg_act_max);
    return int'(o);
  endfunction

  // ---------------- helpers (stimulus only) ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cfg(input int n, input int bias, input int mult, input int shift,
                         input int off, input int lo, input int hi);
    cfg_num_ch     = 16'(n);
    cfg_bias       = bias;
    cfg_mult       = mult;
    cfg_shift      = 5'(shift);
    cfg_out_offset = off;
    cfg_act_min    = 8'(lo);
    cfg_act_max    = 8'(hi);
  endtask

  task automatic send(input int v, output bit ok);
    int k;
    k = 0;
    acc_in     = v;
    acc_in_vld = 1'b1;
    #1;
    while (!in_rdy && k < 50) begin
      tick();
      #1;
      k++;
    end
    ok = in_rdy;
    tick();
    acc_in_vld = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    #1;
    while (!out_vld && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic consume();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
  endtask

  task automatic count_extra(output int n);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_vld) n++;
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
    checks++; if (out_data !== 8'sd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    bit ok;
    int cyc;
    int ins[2]  = '{100, -100};
    int exps[2] = '{50, -50};
    set_cfg(1, 0, 32'h4000_0000, 0, 0, -128, 127);
    foreach (ins[i]) begin
      send(ins[i], ok);
      wait_out(cyc);
      checks++; if (cyc != 3) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 3", i, cyc); end
      checks++; if (int'(out_data) != exps[i]) begin errors++; $display("FAIL basic_data[%0d] got %0d want %0d", i, out_data, exps[i]); end
      consume();
    end
  endtask

  task automatic test_multi_ch();
    bit ok;
    int cyc, extra;
    set_cfg(3, 40, 32'h7FFF_FFFF, 2, -128, -128, 127);
    send(10, ok);
    send(20, ok);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multi_busy got %b want 1", busy); end
    send(30, ok);
    wait_out(cyc);
    checks++; if (cyc != 3) begin errors++; $display("FAIL multi_latency got %0d want 3", cyc); end
    checks++; if (int'(out_data) != -103) begin errors++; $display("FAIL multi_data got %0d want -103", out_data); end
    consume();
    count_extra(extra);
    checks++; if (extra != 0) begin errors++; $display("FAIL multi_extra got %0d outputs want 0", extra); end
  endtask

  task automatic test_clamp();
    bit ok;
    int cyc;
    int ins[3]  = '{1000, 1000, -500};
    int los[3]  = '{-128, 0, 0};
    int his[3]  = '{127, 6, 6};
    int exps[3] = '{127, 6, 0};
    foreach (ins[i]) begin
      set_cfg(1, 0, 32'h7FFF_FFFF, 0, 0, los[i], his[i]);
      send(ins[i], ok);
      wait_out(cyc);
      checks++; if (int'(out_data) != exps[i]) begin errors++; $display("FAIL clamp[%0d] got %0d want %0d", i, out_data, exps[i]); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    int got[$];
    int want[3] = '{10, 20, 30};
    set_cfg(1, 0, 32'h4000_0000, 0, 0, -128, 127);
    out_rdy = 1'b0;
    send(20, ok);
    send(40, ok);
    send(60, ok);
    wait_out(cyc);
    acc_in     = 99;
    acc_in_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy[%0d] got %b want 0", i, in_rdy); end
      checks++; if (out_vld !== 1'b1 || int'(out_data) != 10) begin
        errors++; $display("FAIL bp_hold[%0d] got vld %b data %0d want 1/10", i, out_vld, out_data);
      end
      tick();
    end
    acc_in_vld = 1'b0;
    out_rdy    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_vld) got.push_back(int'(out_data));
      tick();
    end
    out_rdy = 1'b0;
    checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", got.size()); end
    foreach (want[i]) begin
      checks++;
      if (i >= got.size() || got[i] != want[i]) begin
        errors++; $display("FAIL bp_order[%0d] got %0d want %0d", i, (i < got.size()) ? got[i] : -999, want[i]);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int cyc, want;
`ifdef FS_ACCEL_ACC_QUANT_SAT_EN
    want = 127;
`else
    want = -128;
`endif
    set_cfg(2, 0, 32'h7FFF_FFFF, 0, 0, -128, 127);
    send(32'h7FFF_FFFF, ok);
    send(1, ok);
    wait_out(cyc);
    checks++; if (int'(out_data) != want) begin errors++; $display("FAIL overflow got %0d want %0d", out_data, want); end
    consume();
  endtask

  task automatic test_flush(input bit use_reset);
    bit ok;
    int cyc, extra;
    set_cfg(3, 0, 32'h7FFF_FFFF, 0, 0, -128, 127);
    send(7, ok);
    send(9, ok);
    acc_in     = 100;
    acc_in_vld = 1'b1;
    if (use_reset) reset = 1'b1; else clear = 1'b1;
    tick();
    reset      = 1'b0;
    clear      = 1'b0;
    acc_in_vld = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy[%0d] got %b want 0", use_reset, busy); end
    if (use_reset) begin
      checks++; if (in_rdy !== 1'b1 || out_vld !== 1'b0 || out_data !== 8'sd0) begin
        errors++; $display("FAIL flush_reset_vals got rdy %b vld %b data %0d want 1/0/0", in_rdy, out_vld, out_data);
      end
    end
    send(5, ok);
    send(5, ok);
    send(5, ok);
    wait_out(cyc);
    checks++; if (cyc != 3 || int'(out_data) != 15) begin
      errors++; $display("FAIL flush_data[%0d] got %0d (lat %0d) want 15 (lat 3)", use_reset, out_data, cyc);
    end
    consume();
    count_extra(extra);
    checks++; if (extra != 0) begin errors++; $display("FAIL flush_extra[%0d] got %0d want 0", use_reset, extra); end
  endtask

  task automatic test_random();
    for (int round = 0; round < 20; round++) begin
      int parts[$];
      int exp_q[$];
      int n, npix, idx, cyc, a, b;
      bit acc_now, cons_now;
      n = $urandom_range(0, 4);
      a = $urandom_range(0, 255) - 128;
      b = $urandom_range(0, 255) - 128;
      set_cfg(n, int'($urandom) >>> $urandom_range(12, 31), int'($urandom), $urandom_range(0, 8),
              $urandom_range(0, 255) - 128, (a < b) ? a : b, (a < b) ? b : a);
      npix = $urandom_range(3, 8);
      for (int p = 0; p < npix; p++) begin
        int s;
        s = 0;
        for (int c = 0; c < ((n == 0) ? 1 : n); c++) begin
          int v;
          v = int'($urandom) >>> $urandom_range(8, 31);
          parts.push_back(v);
          s = model_add(s, v);
        end
        exp_q.push_back(model_quant(model_add(s, cfg_bias)));
      end
      idx = 0;
      cyc = 0;
      while ((idx < parts.size() || exp_q.size() != 0) && cyc < 2000) begin
        acc_in_vld = (idx < parts.size()) && ($urandom_range(0, 3) != 0);
        acc_in     = (idx < parts.size()) ? parts[idx] : 0;
        out_rdy    = ($urandom_range(0, 2) != 0);
        #1;
        acc_now  = acc_in_vld && in_rdy;
        cons_now = out_vld && out_rdy;
        if (cons_now) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL rand_spurious r%0d got %0d want none", round, out_data);
          end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(out_data) != e) begin errors++; $display("FAIL rand_data r%0d got %0d want %0d", round, out_data, e); end
          end
        end
        tick();
        if (acc_now) idx++;
        cyc++;
      end
      acc_in_vld = 1'b0;
      out_rdy    = 1'b0;
      checks++;
      if (cyc >= 2000) begin
        errors++; $display("FAIL rand_timeout r%0d got %0d pending want 0", round, exp_q.size());
      end
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_idle r%0d got busy %b want 0", round, busy); end
    end
  endtask

  initial begin
    reset      = 1'b1;
    clear      = 1'b0;
    acc_in_vld = 1'b0;
    acc_in     = 0;
    out_rdy    = 1'b0;
    set_cfg(1, 0, 32'h4000_0000, 0, 0, -128, 127);
    @(negedge clk);
    test_reset();
    test_basic();
    test_multi_ch();
    test_clamp();
    test_backpressure();
    test_overflow();
    test_flush(1'b0);
    test_flush(1'b1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
